// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-add multiplier: one ripple-carry add plus right shift per cycle.
// Product and one-cycle done arrive WIDTH cycles after start; start is ignored while busy.
module seq_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    logic             last;
    logic             load;
    logic             step;

    assign addend   = mplier[0] ? mcand : '0;
    assign carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            assign sum[i]     = acc[i] ^ addend[i] ^ carry[i];
            assign carry[i+1] = (acc[i] & addend[i]) | (carry[i] & (acc[i] ^ addend[i]));
        end
    endgenerate

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                mcand  <= a;
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
            end else if (step) begin
                // {carry-out, sum, multiplier} shifted right by one; the multiplier LSB drops out.
                acc    <= {carry[WIDTH], sum[WIDTH-1:1]};
                mplier <= {sum[0], mplier[WIDTH-1:1]};
                cnt    <= cnt + CW'(1);
                if (last) begin
                    product <= {carry[WIDTH], sum, mplier[WIDTH-1:1]};
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Randomised and directed bench for seq_shift_add_mult at WIDTH=8 against an a*b reference.
`timescale 1ns/1ps
module tb_seq_shift_add_mult;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int compared;
    int mismatched;

    seq_shift_add_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the product is the plain unsigned product of the operands seen at start.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        return (2*W)'(x) * (2*W)'(y);
    endfunction

    // Launches one operation and observes it; no checking here.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit scramble,
                          output int lat, output logic [2*W-1:0] prod, output int busy_cnt,
                          output bit prod_stable, output logic done_next);
        logic [2*W-1:0] prev;
        prev        = product;
        prod_stable = 1'b1;
        a = xa; b = xb; start = 1'b1;
        tick();
        start    = 1'b0;
        lat      = -1;
        prod     = 'x;
        busy_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (busy) busy_cnt++;
            if (product !== prev) prod_stable = 1'b0;
            if (scramble) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            tick();
            if (done) begin
                lat  = c;
                prod = product;
                break;
            end
        end
        tick();
        done_next = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF;
        tick(); tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
        compared++; if (product !== '0) begin mismatched++; $display("FAIL reset_product: got %h want 0000", product); end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_idle_after: got %b want 0", busy); end
    endtask

    task automatic test_corners();
        logic [W-1:0]   ta [3];
        logic [W-1:0]   tb [3];
        int             lat, bc;
        logic [2*W-1:0] prod;
        bit             stable;
        logic           dn;
        ta[0] = 8'hFF; tb[0] = 8'hFF;
        ta[1] = 8'h00; tb[1] = 8'hA5;
        ta[2] = 8'h5A; tb[2] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            run_op(ta[k], tb[k], 1'b0, lat, prod, bc, stable, dn);
            compared++; if (prod !== ref_mul(ta[k], tb[k])) begin mismatched++; $display("FAIL corner%0d_product: got %h want %h", k, prod, ref_mul(ta[k], tb[k])); end
            compared++; if (lat !== W) begin mismatched++; $display("FAIL corner%0d_latency: got %0d want %0d", k, lat, W); end
            compared++; if (bc !== W) begin mismatched++; $display("FAIL corner%0d_busy_cycles: got %0d want %0d", k, bc, W); end
            compared++; if (stable !== 1'b1) begin mismatched++; $display("FAIL corner%0d_product_stable: got %b want 1", k, stable); end
            compared++; if (dn !== 1'b0) begin mismatched++; $display("FAIL corner%0d_done_width: got %b want 0", k, dn); end
        end
        compared++; if (16'hFE01 !== ref_mul(8'hFF, 8'hFF) || product !== 16'h0000) begin mismatched++; $display("FAIL corner_last_product: got %h want 0000", product); end
    endtask

    task automatic test_ignore_start();
        int             dones;
        int             first;
        logic [2*W-1:0] got;
        a = 8'h0D; b = 8'h0B; start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0; first = -1; got = 'x;
        for (int c = 1; c <= 25; c++) begin
            if (c == 3) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                dones++;
                if (first < 0) begin first = c; got = product; end
            end
        end
        compared++; if (dones !== 1) begin mismatched++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
        compared++; if (first !== W) begin mismatched++; $display("FAIL ignore_latency: got %0d want %0d", first, W); end
        compared++; if (got !== ref_mul(8'h0D, 8'h0B)) begin mismatched++; $display("FAIL ignore_product: got %h want %h", got, ref_mul(8'h0D, 8'h0B)); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ignore_idle: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int last_done;
        int dones;
        a = 8'h03; b = 8'h05; start = 1'b1;
        tick();
        last_done = 0; dones = 0;
        for (int c = 1; c <= 36; c++) begin
            tick();
            compared++; if (busy !== ~done) begin mismatched++; $display("FAIL b2b_busy_c%0d: got busy=%b done=%b want busy=~done", c, busy, done); end
            if (done) begin
                dones++;
                compared++; if (c - last_done !== ((last_done == 0) ? W : W + 1)) begin mismatched++; $display("FAIL b2b_interval_c%0d: got %0d", c, c - last_done); end
                compared++; if (product !== ref_mul(8'h03, 8'h05)) begin mismatched++; $display("FAIL b2b_product_c%0d: got %h want %h", c, product, ref_mul(8'h03, 8'h05)); end
                last_done = c;
            end
        end
        compared++; if (dones !== 4) begin mismatched++; $display("FAIL b2b_done_count: got %0d want 4", dones); end
        start = 1'b0;
        for (int c = 0; c < 20 && busy; c++) tick();
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_drain: got busy %b want 0", busy); end
    endtask

    task automatic test_reset_abort();
        int             dones;
        int             lat, bc;
        logic [2*W-1:0] prod;
        bit             stable;
        logic           dn;
        a = 8'h80; b = 8'h80; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b want 0", busy); end
        compared++; if (product !== '0) begin mismatched++; $display("FAIL abort_product: got %h want 0000", product); end
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) dones++;
            tick();
        end
        compared++; if (dones !== 0) begin mismatched++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
        compared++; if (product !== '0) begin mismatched++; $display("FAIL abort_product_hold: got %h want 0000", product); end
        run_op(8'h80, 8'h80, 1'b0, lat, prod, bc, stable, dn);
        compared++; if (prod !== 16'h4000) begin mismatched++; $display("FAIL abort_restart_product: got %h want 4000", prod); end
        compared++; if (lat !== W) begin mismatched++; $display("FAIL abort_restart_latency: got %0d want %0d", lat, W); end
    endtask

    task automatic test_random();
        logic [W-1:0]   ra, rb;
        int             lat, bc;
        logic [2*W-1:0] prod;
        bit             stable;
        logic           dn;
        for (int n = 0; n < 3000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'b1, lat, prod, bc, stable, dn);
            compared++; if (prod !== ref_mul(ra, rb)) begin mismatched++; $display("FAIL rand%0d_product: a=%h b=%h got %h want %h", n, ra, rb, prod, ref_mul(ra, rb)); end
            compared++; if (lat !== W) begin mismatched++; $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, W); end
            compared++; if (dn !== 1'b0) begin mismatched++; $display("FAIL rand%0d_done_width: got %b want 0", n, dn); end
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_corners();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
